irq_controller: RTL
===================

# irq_controller

Exception-entry initiator for the MIPS core: detects peripheral interrupt edges, holds them pending, selects the highest-priority enabled one at an instruction boundary, and drives the coprocessor's EPC/Cause write strobes and the cause code. Also redirects the fetch PC to the handler vector on entry and back to EPC on ERET. Sits between the peripheral IRQ lines, the control FSM (boundary/ERET) and the coprocessor register file.

## Interface
- `NUM_IRQ`, 4: number of IRQ lines, legal range 1..4 because the cause field is 2 bits.
- `VECTOR`, 32'h0000_0100: handler entry address.
- `clk` in 1: the only clock.
- `rst_n` in 1: synchronous, active-low reset.
- `irq_i` in NUM_IRQ: peripheral requests, synchronous to `clk`, rising-edge sensitive.
- `irq_mask_i` in NUM_IRQ: per-line enable (1 = enabled).
- `int_en_i` in 1: global interrupt enable.
- `boundary_i` in 1: core is at an instruction boundary this cycle; an interrupt may be taken.
- `pc_i` in 32: resume PC, valid when `boundary_i`=1.
- `eret_i` in 1: ERET retiring; qualified by `boundary_i`.
- `epc_i` in 32: current EPC read back from the coprocessor.
- `epc_write_o` out 1: EPC write strobe.
- `epc_data_o` out 32: value to write into EPC.
- `cause_write_o` out 1: Cause write strobe.
- `int_cause_o` out 2: index of the taken line.
- `redirect_o` out 1: single-cycle PC override.
- `redirect_pc_o` out 32: PC target for the override.
- `in_handler_o` out 1: high while the handler runs; the core must not take a second interrupt.
- `pending_o` out NUM_IRQ: pending bits, for debug and readback.

## Operation
- Edge detect:
  - `irq_q` is `irq_i` registered and resets to 0. A line already high when reset releases therefore counts as an edge.
  - A set condition `irq_i & ~irq_q` sets the matching pending bit.
- Eligible lines = `pending & irq_mask_i`. Take condition = `int_en_i & boundary_i & |eligible` while in state IDLE.
- Priority: the lowest index wins. The winner's index is `int_cause_o`.
- FSM has states IDLE and HANDLER.
  - IDLE → HANDLER on the take condition. ERET in IDLE is ignored and produces no redirect.
  - HANDLER → IDLE on `eret_i & boundary_i`. No takes are allowed in HANDLER. Edges are still latched as pending.
- On take, in the following cycle:
  - `epc_write_o`, `cause_write_o` and `redirect_o` each pulse 1 for exactly one cycle.
  - `epc_data_o` = captured `pc_i`.
  - `int_cause_o` = captured index.
  - `redirect_pc_o` = `VECTOR`.
  - The winner's pending bit clears.
- On ERET exit, in the following cycle: `redirect_o` pulses 1 and `redirect_pc_o` = `epc_i` as sampled on the ERET cycle. No write strobes.
- Simultaneous set and clear of the same pending bit: set wins, so the new edge is not lost.
- A mask or `int_en_i` change affects only future takes. Pending bits persist while masked.
- A boundary cycle with nothing eligible does nothing.

## Timing
- Reset (`rst_n`=0 at a `clk` edge):
  - state = IDLE; pending, `irq_q` and all strobes = 0.
  - `epc_data_o`, `redirect_pc_o` and `int_cause_o` = 0.
  - `in_handler_o` = 0.
- Reset mid-handler forces IDLE, drops pending, and cancels any strobe due in the next cycle.
- Edge to pending: 1 cycle. Boundary to strobes: 1 cycle. ERET to redirect: 1 cycle.
- `in_handler_o` rises in the same cycle as the entry strobes. It falls in the same cycle as the ERET redirect.
- All outputs are registered.
- Minimum edge-to-handler latency is 2 cycles: edge at N, pending at N+1, take at N+1 if `boundary_i` is high then, strobes at N+2.

## Structure
- Package `irq_pkg`: FSM state enum (IDLE, HANDLER), cause width constant (2), default `VECTOR`.
- Sub-module `irq_pending`: edge detect plus the pending register, with set-over-clear. Top level holds the priority encoder, the FSM and the output registers.

## Test plan
- Reset release with `irq_i`=4'b0000, then a pulse on irq[2], mask 4'b1111, int_en=1, boundary held 1 → two cycles after the edge: one-cycle `epc_write_o`/`cause_write_o`, `int_cause_o`=2, `epc_data_o`=`pc_i`, `redirect_pc_o`=0x100, `pending_o`=0.
- Edges on irq[3] and irq[1] in the same cycle → line 1 is taken first. After ERET, the next boundary takes line 3 with `int_cause_o`=3.
- Edge on irq[0] while in HANDLER → no strobe. After ERET with `epc_i`=0x0000_2040: redirect to 0x2040 one cycle later, then a take of line 0 at the next boundary.
- irq[1] pending with mask bit 1 = 0 → no take for 20 cycles. Unmask → take at the next boundary. Repeat the check with `int_en_i`=0.
- Take cycle coincides with a fresh edge on the same line → the line is taken and its pending bit stays 1.
- `rst_n`=0 asserted in HANDLER with pending 4'b0110 → next cycle all outputs are 0, state is IDLE, and no redirect occurs on a later ERET.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller: FSM states,
// cause field width and the default handler entry address.
package irq_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_HANDLER = 1'b1
    } state_e;

    localparam int          CAUSE_W        = 2;
    localparam logic [31:0] DEFAULT_VECTOR = 32'h0000_0100;

endpackage

// File: rtl/irq_pending.sv
// Rising-edge detector and pending register for the IRQ lines.
// A new edge and a clear on the same bit in the same cycle leave the bit set.
module irq_pending #(
    parameter int NUM_IRQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] clr_i,
    output logic [NUM_IRQ-1:0] pending_o
);

    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] pend_d;
    logic [NUM_IRQ-1:0] rise;

    assign rise   = irq_i & ~irq_q;
    assign pend_d = (pend_q & ~clr_i) | rise;

    // irq_q resets low, so a line held high across reset release registers as an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_q  <= '0;
            pend_q <= '0;
        end else begin
            irq_q  <= irq_i;
            pend_q <= pend_d;
        end
    end

    assign pending_o = pend_q;

endmodule

// File: rtl/irq_controller.sv
// Exception-entry initiator: picks the lowest-index enabled pending IRQ at an
// instruction boundary, strobes EPC/Cause writes and redirects fetch on entry and ERET.
module irq_controller
    import irq_pkg::*;
#(
    parameter int          NUM_IRQ = 4,
    parameter logic [31:0] VECTOR  = DEFAULT_VECTOR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] irq_mask_i,
    input  logic               int_en_i,
    input  logic               boundary_i,
    input  logic [31:0]        pc_i,
    input  logic               eret_i,
    input  logic [31:0]        epc_i,
    output logic               epc_write_o,
    output logic [31:0]        epc_data_o,
    output logic               cause_write_o,
    output logic [1:0]         int_cause_o,
    output logic               redirect_o,
    output logic [31:0]        redirect_pc_o,
    output logic               in_handler_o,
    output logic [NUM_IRQ-1:0] pending_o
);

    state_e               state_q, state_d;
    logic [NUM_IRQ-1:0]   pending;
    logic [NUM_IRQ-1:0]   eligible;
    logic [NUM_IRQ-1:0]   clr;
    logic [CAUSE_W-1:0]   win;
    logic                 take;
    logic                 leave;

    logic                 epc_write_q, epc_write_d;
    logic                 cause_write_q, cause_write_d;
    logic                 redirect_q, redirect_d;
    logic [31:0]          epc_data_q, epc_data_d;
    logic [CAUSE_W-1:0]   int_cause_q, int_cause_d;
    logic [31:0]          redirect_pc_q, redirect_pc_d;

    irq_pending #(
        .NUM_IRQ(NUM_IRQ)
    ) u_pending (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq_i    (irq_i),
        .clr_i    (clr),
        .pending_o(pending)
    );

    assign eligible = pending & irq_mask_i;

    // Scan from the top down so the lowest eligible index is the last to assign.
    always_comb begin
        win = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) win = CAUSE_W'(i);
        end
    end

    assign take  = (state_q == ST_IDLE) && int_en_i && boundary_i && (|eligible);
    assign leave = (state_q == ST_HANDLER) && eret_i && boundary_i;
    assign clr   = take ? (NUM_IRQ'(1) << win) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (take)  state_d = ST_HANDLER;
            ST_HANDLER: if (leave) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Strobes are one-shot; data fields hold their last written value.
    always_comb begin
        epc_write_d   = 1'b0;
        cause_write_d = 1'b0;
        redirect_d    = 1'b0;
        epc_data_d    = epc_data_q;
        int_cause_d   = int_cause_q;
        redirect_pc_d = redirect_pc_q;
        if (take) begin
            epc_write_d   = 1'b1;
            cause_write_d = 1'b1;
            redirect_d    = 1'b1;
            epc_data_d    = pc_i;
            int_cause_d   = win;
            redirect_pc_d = VECTOR;
        end else if (leave) begin
            redirect_d    = 1'b1;
            redirect_pc_d = epc_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            epc_write_q   <= 1'b0;
            cause_write_q <= 1'b0;
            redirect_q    <= 1'b0;
            epc_data_q    <= '0;
            int_cause_q   <= '0;
            redirect_pc_q <= '0;
        end else begin
            epc_write_q   <= epc_write_d;
            cause_write_q <= cause_write_d;
            redirect_q    <= redirect_d;
            epc_data_q    <= epc_data_d;
            int_cause_q   <= int_cause_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign epc_write_o   = epc_write_q;
    assign cause_write_o = cause_write_q;
    assign redirect_o    = redirect_q;
    assign epc_data_o    = epc_data_q;
    assign int_cause_o   = int_cause_q;
    assign redirect_pc_o = redirect_pc_q;
    assign in_handler_o  = (state_q == ST_HANDLER);
    assign pending_o     = pending;

endmodule
